pl_hazard_ctrl: RTL and testbench

- Central pipeline controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB); instantiated in pl_main.
- Detects load-use hazards and generates forwarding selects.
- Flushes wrong-path instructions on taken branches resolved in EX.
- Freezes the whole pipeline while a data-memory access waits; keeps saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pl_pkg.sv | 16 +
 rtl/pl_fwd_unit.sv | 30 +++
 rtl/pl_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pl_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding selects,
// FSM state encoding and the register-index width.
package pl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } pl_state_t;

endpackage

// File: rtl/pl_fwd_unit.sv
// Combinational forwarding select for one EX operand; the MEM-stage producer
// is younger than the WB-stage one, so it wins when both match.
module pl_fwd_unit
    import pl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output logic [1:0]       sel
);

    logic mem_hit;
    logic wb_hit;

    // r0 is hardwired to zero, so a write to it never forwards.
    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == src);

    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch flush, load-use
// stall, operand forwarding, saturating perf counters and sticky timeout error.
module pl_hazard_ctrl
    import pl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_err,
    output logic             fsm_state
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WC_W-1:0]  TIMEOUT_VAL = WC_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    pl_state_t       state;
    logic [WC_W-1:0] wait_cnt;

    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       in_wait;
    logic       timeout;
    logic       freeze;
    logic       load_use;

    pl_fwd_unit u_fwd_a (
        .src           (ex_rs),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_raw)
    );

    pl_fwd_unit u_fwd_b (
        .src           (ex_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_raw)
    );

    assign in_wait  = (state == ST_MEM_WAIT);
    assign timeout  = in_wait && !dmem_ready && (wait_cnt == TIMEOUT_VAL);
    assign freeze   = ((state == ST_RUN) && dmem_req && !dmem_ready)
                   || (in_wait && !dmem_ready && !timeout);
    assign load_use = ex_mem_read && (ex_rd != '0)
                   && ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign fsm_state = state;

    // Priority: reset, memory freeze, branch flush, load-use stall.
    // A timed-out access releases the pipe but its MEM result is dropped.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = timeout;
        fwd_a         = fwd_a_raw;
        fwd_b         = fwd_b_raw;
        if (rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
            fwd_a         = FWD_REG;
            fwd_b         = FWD_REG;
        end else if (freeze) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            stall_cycles <= '0;
            flush_count  <= '0;
            mem_err      <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (timeout) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (!pc_en && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed bench for pl_hazard_ctrl: single-cycle vector table plus
// hand-written memory-wait, timeout, saturation and async-reset sequences.
module tb_pl_hazard_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Packed output order: pc,if_id,id_ex,ex_mem enables | if_id_flush,id_ex_flush | bubble | fwd_a | fwd_b
    localparam logic [10:0] O_IDLE   = {4'b1111, 2'b00, 1'b0, 2'b00, 2'b00};
    localparam logic [10:0] O_LDUSE  = {4'b0011, 2'b01, 1'b0, 2'b00, 2'b00};
    localparam logic [10:0] O_BRANCH = {4'b1111, 2'b11, 1'b0, 2'b00, 2'b00};
    localparam logic [10:0] O_FREEZE = {4'b0000, 2'b00, 1'b1, 2'b00, 2'b00};
    localparam logic [10:0] O_TMOUT  = {4'b1111, 2'b00, 1'b1, 2'b00, 2'b00};
    localparam logic [10:0] O_RESET  = {4'b0000, 2'b11, 1'b1, 2'b00, 2'b00};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken;
    logic       mem_reg_write, wb_reg_write, dmem_req, dmem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic       if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [1:0] fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic       mem_err, fsm_state;

    int n_vec = 0;
    int n_bad = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;

    typedef struct {
        string       name;
        logic [4:0]  id_rs, id_rt;
        logic        id_uses_rs, id_uses_rt;
        logic [4:0]  ex_rs, ex_rt, ex_rd;
        logic        ex_mem_read, ex_branch_taken;
        logic [4:0]  mem_rd;
        logic        mem_reg_write;
        logic [4:0]  wb_rd;
        logic        wb_reg_write;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[14];

    pl_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .mem_reg_write   (mem_reg_write),
        .wb_rd           (wb_rd),
        .wb_reg_write    (wb_reg_write),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .mem_err         (mem_err),
        .fsm_state       (fsm_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mkv(string name, logic [4:0] irs, logic [4:0] irt, logic urs, logic urt,
                                 logic [4:0] ers, logic [4:0] ert, logic [4:0] erd, logic mr, logic br,
                                 logic [4:0] mrd, logic mw, logic [4:0] wrd, logic ww, logic [10:0] exp);
        vec_t v;
        v.name = name; v.id_rs = irs; v.id_rt = irt; v.id_uses_rs = urs; v.id_uses_rt = urt;
        v.ex_rs = ers; v.ex_rt = ert; v.ex_rd = erd; v.ex_mem_read = mr; v.ex_branch_taken = br;
        v.mem_rd = mrd; v.mem_reg_write = mw; v.wb_rd = wrd; v.wb_reg_write = ww; v.exp = exp;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                mem_wb_bubble, fwd_a, fwd_b};
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Compare outputs mid-cycle, clock, then advance the counter model from
    // the expected (not observed) enables and flushes.
    task automatic run_cycle(string name, logic [10:0] exp);
        @(negedge clk);
        check(name, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
        if (!exp[10] && exp_stall != CNT_MAX) exp_stall = exp_stall + 1'b1;
        if (exp[6] && exp_flush != CNT_MAX) exp_flush = exp_flush + 1'b1;
    endtask

    task automatic check_counters(string name);
        check({name, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
        check({name, "_flush"}, 32'(flush_count), 32'(exp_flush));
    endtask

    initial begin
        idle_inputs();
        vecs[0]  = mkv("idle",         0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_IDLE);
        vecs[1]  = mkv("lduse_rs",     8, 0, 1, 0,  0, 0, 8, 1, 0,  0, 0, 0, 0, O_LDUSE);
        vecs[2]  = mkv("after_lduse",  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, O_IDLE);
        vecs[3]  = mkv("lduse_rt",     0, 9, 0, 1,  0, 0, 9, 1, 0,  0, 0, 0, 0, O_LDUSE);
        vecs[4]  = mkv("rt_not_used",  0, 9, 0, 0,  0, 0, 9, 1, 0,  0, 0, 0, 0, O_IDLE);
        vecs[5]  = mkv("lduse_r0",     0, 0, 1, 1,  0, 0, 0, 1, 0,  0, 0, 0, 0, O_IDLE);
        vecs[6]  = mkv("no_load",      8, 0, 1, 0,  0, 0, 8, 0, 0,  0, 0, 0, 0, O_IDLE);
        vecs[7]  = mkv("fwd_mem_prio", 0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 1, 5, 1, {O_IDLE[10:4], 2'b10, 2'b00});
        vecs[8]  = mkv("fwd_wb",       0, 0, 0, 0,  5, 0, 0, 0, 0,  5, 0, 5, 1, {O_IDLE[10:4], 2'b01, 2'b00});
        vecs[9]  = mkv("fwd_rs0",      0, 0, 0, 0,  0, 0, 0, 0, 0,  5, 1, 5, 1, O_IDLE);
        vecs[10] = mkv("fwd_rd0",      0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 0, 1, O_IDLE);
        vecs[11] = mkv("fwd_a_mem_b_wb", 0, 0, 0, 0, 3, 7, 0, 0, 0, 3, 1, 7, 1, {O_IDLE[10:4], 2'b10, 2'b01});
        vecs[12] = mkv("branch_lduse", 8, 0, 1, 0,  0, 0, 8, 1, 1,  0, 0, 0, 0, O_BRANCH);
        vecs[13] = mkv("branch",       0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0, O_BRANCH);

        // Reset state while rst is held.
        #2;
        check("reset_outs", 32'(outs()), 32'(O_RESET));
        check("reset_stall", 32'(stall_cycles), 0);
        check("reset_merr", 32'(mem_err), 0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt;
            id_uses_rs = vecs[i].id_uses_rs; id_uses_rt = vecs[i].id_uses_rt;
            ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt; ex_rd = vecs[i].ex_rd;
            ex_mem_read = vecs[i].ex_mem_read; ex_branch_taken = vecs[i].ex_branch_taken;
            mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_reg_write;
            wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_reg_write;
            run_cycle(vecs[i].name, vecs[i].exp);
            if (i == 1) check("lduse_stall_cnt", 32'(stall_cycles), 1);
        end
        check_counters("table");
        idle_inputs();

        // Memory wait of 4 cycles with a taken branch held in EX meanwhile.
        dmem_req = 1'b1;
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_cycle("memwait_frozen", O_FREEZE);
            if (k == 0) check("memwait_state", 32'(fsm_state), 1);
        end
        dmem_ready = 1'b1;
        run_cycle("memwait_release", O_BRANCH);
        idle_inputs();
        check("memwait_state_run", 32'(fsm_state), 0);
        check("memwait_merr", 32'(mem_err), 0);
        check_counters("memwait");

        // Timeout: 8 frozen cycles, then forced release with MEM result dropped.
        dmem_req = 1'b1;
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            run_cycle("tmout_frozen", O_FREEZE);
        end
        check("tmout_merr_before", 32'(mem_err), 0);
        run_cycle("tmout_release", O_TMOUT);
        check("tmout_merr", 32'(mem_err), 1);
        check("tmout_state_run", 32'(fsm_state), 0);
        idle_inputs();
        run_cycle("after_tmout", O_IDLE);
        check("merr_sticky", 32'(mem_err), 1);
        check_counters("tmout");

        // Drive both counters into saturation.
        ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
        for (int k = 0; k < 3; k++) run_cycle("sat_lduse", O_LDUSE);
        check("stall_saturated", 32'(stall_cycles), 32'(CNT_MAX));
        idle_inputs();
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 15; k++) run_cycle("sat_branch", O_BRANCH);
        check("flush_saturated", 32'(flush_count), 32'(CNT_MAX));
        check_counters("sat");
        idle_inputs();

        // Async reset in the middle of a memory wait, between clock edges.
        dmem_req = 1'b1;
        run_cycle("rstwait_frozen", O_FREEZE);
        run_cycle("rstwait_frozen", O_FREEZE);
        ex_rs = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", 32'(outs()), 32'(O_RESET));
        check("async_rst_state", 32'(fsm_state), 0);
        check("async_rst_stall", 32'(stall_cycles), 0);
        check("async_rst_flush", 32'(flush_count), 0);
        check("async_rst_merr", 32'(mem_err), 0);
        exp_stall = '0;
        exp_flush = '0;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_cycle("post_rst_idle", O_IDLE);
        check("post_rst_state", 32'(fsm_state), 0);
        check("post_rst_merr", 32'(mem_err), 0);
        check_counters("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
